// File: rtl/ram_port_arbiter_if.sv
// Request/response bundle for one RAM requester port.
// master: requester (req/we/lock/addr/wdata out); slave: arbiter side.
interface ram_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU (p0) and DMA (p1).
// Ports: Clock, Resetn (sync, active-low); p0/p1 requester interfaces;
// mem_addr/mem_wdata/mem_we/mem_rdata RAM side; busy.
// Optional ARB_STATS_EN adds stat_gnt0, stat_gnt1, stat_conflict counters.
module ram_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic          Clock,
    input  logic          Resetn,
    ram_port_arbiter_if.slave p0,
    ram_port_arbiter_if.slave p1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_conflict
`endif
);

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    logic              last_owner;
    logic              last_lock;
    logic [7:0]        burst_cnt;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_o;

    logic both;
    logic hold;
    logic owner;
    logic g0;
    logic g1;
    logic other_req;
    logic rd_issue;
    logic rv;

    // Grant: lock keeps the previous owner only while the burst
    // cap is not reached; otherwise alternate.
    always_comb begin
        both  = p0.req & p1.req;
        hold  = last_lock && (burst_cnt < MAXB);
        owner = 1'b0;
        g0    = 1'b0;
        g1    = 1'b0;
        if (Resetn) begin
            if (both) begin
                owner = hold ? last_owner : ~last_owner;
                g0    = ~owner;
                g1    = owner;
            end else begin
                g0 = p0.req;
                g1 = p1.req;
            end
        end
    end

    always_comb begin
        other_req = g1 ? p0.req : p1.req;
        rd_issue  = (g0 & ~p0.we) | (g1 & ~p1.we);
        mem_addr  = g1 ? p1.addr  : p0.addr;
        mem_wdata = g1 ? p1.wdata : p0.wdata;
        mem_we    = (g0 & p0.we) | (g1 & p1.we);
        rv        = Resetn & pipe_v[RD_LAT-1];
        busy      = Resetn & ((|pipe_v) | g0 | g1);
    end

    assign p0.gnt    = g0;
    assign p1.gnt    = g1;
    assign p0.rvalid = rv & ~pipe_o[RD_LAT-1];
    assign p1.rvalid = rv &  pipe_o[RD_LAT-1];
    assign p0.rdata  = p0.rvalid ? mem_rdata : '0;
    assign p1.rdata  = p1.rvalid ? mem_rdata : '0;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            last_owner <= 1'b1;
            last_lock  <= 1'b0;
            burst_cnt  <= '0;
            pipe_v     <= '0;
            pipe_o     <= '0;
        end else begin
            if (g0 | g1) begin
                last_owner <= g1;
                last_lock  <= g1 ? p1.lock : p0.lock;
                if ((g1 != last_owner) || !other_req)
                    burst_cnt <= 8'd1;
                else if (burst_cnt < MAXB)
                    burst_cnt <= burst_cnt + 8'd1;
            end else begin
                burst_cnt <= '0;
            end
            // Owner tag travels with the read so data returns in order.
            pipe_v[0] <= rd_issue;
            pipe_o[0] <= g1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_o[i] <= pipe_o[i-1];
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (g0 && stat_gnt0 != 16'hFFFF)
                stat_gnt0 <= stat_gnt0 + 16'd1;
            if (g1 && stat_gnt1 != 16'hFFFF)
                stat_gnt1 <= stat_gnt1 + 16'd1;
            if (both && stat_conflict != 16'hFFFF)
                stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 1-cycle RAM.
// Build with +define+ARB_STATS_EN to include the statistics scenario.
module tb_ram_port_arbiter;

    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   cyc;
    } rv_t;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [15:0]   stat_gnt0;
    logic [15:0]   stat_gnt1;
    logic [15:0]   stat_conflict;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    rv_t exp0[$];
    rv_t exp1[$];
    rv_t got0[$];
    rv_t got1[$];

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
    ram_port_arbiter_if #(.AW(AW), .DW(DW)) p1 ();

    ram_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .p0(p0),
        .p1(p1),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef ARB_STATS_EN
        ,
        .stat_gnt0(stat_gnt0),
        .stat_gnt1(stat_gnt1),
        .stat_conflict(stat_conflict)
`endif
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc = cyc + 1;

    // Unwritten locations read back a fixed pattern.
    function automatic logic [DW-1:0] ram_init(input logic [7:0] a);
        return (a == 8'h10) ? 16'h1234 : {8'hA5, a};
    endfunction

    logic [DW-1:0] ram [256];
    bit            wr_done [256];

    always @(posedge Clock) begin
        if (mem_we) begin
            ram[mem_addr[7:0]]     <= mem_wdata;
            wr_done[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= wr_done[mem_addr[7:0]] ?
                     ram[mem_addr[7:0]] : ram_init(mem_addr[7:0]);
    end

    always @(negedge Clock) begin
        if (p0.rvalid) got0.push_back('{p0.rdata, 32'(cyc)});
        if (p1.rvalid) got1.push_back('{p1.rdata, 32'(cyc)});
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        p0.req = 0; p0.we = 0; p0.lock = 0; p0.addr = '0; p0.wdata = '0;
        p1.req = 0; p1.we = 0; p1.lock = 0; p1.addr = '0; p1.wdata = '0;
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        idle();
        repeat (2) tick();
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        p0.req = 1; p0.we = 1; p1.req = 1; p1.we = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if ({p0.gnt, p1.gnt, mem_we, busy, p0.rvalid, p1.rvalid} !== 6'b0) begin
                fails++;
                $display("FAIL reset_outs cyc%0d got=%b want=000000", i,
                    {p0.gnt, p1.gnt, mem_we, busy, p0.rvalid, p1.rvalid});
            end
            tick();
        end
        Resetn = 1'b1;
        idle();
        #1;
        tests++;
        if ({p0.gnt, p1.gnt, busy} !== 3'b0) begin
            fails++;
            $display("FAIL post_reset_idle got=%b want=000", {p0.gnt, p1.gnt, busy});
        end
        tick();
    endtask

    task automatic test_single_read();
        rv_t e, g;
        apply_reset();
        p0.req = 1; p0.we = 0; p0.addr = 16'h0010;
        #1;
        tests++;
        if ({p0.gnt, p1.gnt} !== 2'b10) begin
            fails++;
            $display("FAIL single_gnt got=%b want=10", {p0.gnt, p1.gnt});
        end
        tests++;
        if (mem_addr !== 16'h0010) begin
            fails++;
            $display("FAIL single_addr got=%h want=0010", mem_addr);
        end
        tests++;
        if (p0.rdata !== 16'h0) begin
            fails++;
            $display("FAIL rdata_gated got=%h want=0000", p0.rdata);
        end
        exp0.push_back('{16'h1234, 32'(cyc + RD_LAT)});
        tick();
        idle();
        for (int k = 0; k < 8 && got0.size() < exp0.size(); k++) tick();
        repeat (2) tick();
        tests++;
        if (got0.size() != exp0.size() || got1.size() != 0) begin
            fails++;
            $display("FAIL single_count got0=%0d want=%0d got1=%0d want=0",
                got0.size(), exp0.size(), got1.size());
        end
        while (exp0.size() > 0 && got0.size() > 0) begin
            e = exp0.pop_front();
            g = got0.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL single_rd got=%h@%0d want=%h@%0d", g.d, g.cyc, e.d, e.cyc);
            end
        end
        exp0.delete(); got0.delete(); got1.delete();
    endtask

    task automatic test_back_to_back();
        rv_t e, g;
        logic [AW-1:0] a0, a1, ea;
        logic [1:0] eg;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            a0 = 16'h0030 + 16'(i);
            a1 = 16'h0040 + 16'(i);
            p0.req = 1; p0.we = 0; p0.addr = a0;
            p1.req = 1; p1.we = 0; p1.addr = a1;
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
            ea = (i % 2 == 0) ? a0 : a1;
            #1;
            tests++;
            if ({p0.gnt, p1.gnt} !== eg) begin
                fails++;
                $display("FAIL rr_gnt cyc%0d got=%b want=%b", i, {p0.gnt, p1.gnt}, eg);
            end
            tests++;
            if (mem_addr !== ea) begin
                fails++;
                $display("FAIL rr_addr cyc%0d got=%h want=%h", i, mem_addr, ea);
            end
            if (i % 2 == 0) exp0.push_back('{ram_init(a0[7:0]), 32'(cyc + RD_LAT)});
            else            exp1.push_back('{ram_init(a1[7:0]), 32'(cyc + RD_LAT)});
            tick();
        end
        idle();
        for (int k = 0; k < 8 && (got0.size() < exp0.size() ||
             got1.size() < exp1.size()); k++) tick();
        repeat (2) tick();
        tests++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            fails++;
            $display("FAIL rr_count got=%0d/%0d want=%0d/%0d",
                got0.size(), got1.size(), exp0.size(), exp1.size());
        end
        while (exp0.size() > 0 && got0.size() > 0) begin
            e = exp0.pop_front();
            g = got0.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL rr_rd0 got=%h@%0d want=%h@%0d", g.d, g.cyc, e.d, e.cyc);
            end
        end
        while (exp1.size() > 0 && got1.size() > 0) begin
            e = exp1.pop_front();
            g = got1.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL rr_rd1 got=%h@%0d want=%h@%0d", g.d, g.cyc, e.d, e.cyc);
            end
        end
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
    endtask

    task automatic test_burst_lock();
        logic [1:0] eg;
        apply_reset();
        // Make port 0 the last owner so the locked burst starts on port 1.
        p0.req = 1; p0.we = 1; p0.addr = 16'h0050; p0.wdata = 16'h5050;
        #1;
        tests++;
        if ({p0.gnt, p1.gnt} !== 2'b10) begin
            fails++;
            $display("FAIL burst_pre got=%b want=10", {p0.gnt, p1.gnt});
        end
        tick();
        p0.addr = 16'h0051;
        for (int i = 0; i < 5; i++) begin
            p1.req = 1; p1.we = 1; p1.lock = 1;
            p1.addr = 16'h0060 + 16'(i); p1.wdata = 16'h6000 + 16'(i);
            eg = (i < MAX_BURST) ? 2'b01 : 2'b10;
            #1;
            tests++;
            if ({p0.gnt, p1.gnt} !== eg) begin
                fails++;
                $display("FAIL burst_gnt cyc%0d got=%b want=%b", i, {p0.gnt, p1.gnt}, eg);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        rv_t e, g;
        apply_reset();
        p0.req = 1; p0.we = 1; p0.addr = 16'h0021; p0.wdata = 16'h1111;
        tick();
        p0.we = 0; p0.addr = 16'h0020;
        p1.req = 1; p1.we = 1; p1.addr = 16'h0020; p1.wdata = 16'hBEEF;
        #1;
        tests++;
        if ({p0.gnt, p1.gnt, mem_we, mem_addr, mem_wdata} !==
            {2'b01, 1'b1, 16'h0020, 16'hBEEF}) begin
            fails++;
            $display("FAIL wr_cycle got=%b/%b/%h/%h want=01/1/0020/beef",
                {p0.gnt, p1.gnt}, mem_we, mem_addr, mem_wdata);
        end
        tick();
        p1.req = 0; p1.we = 0;
        #1;
        tests++;
        if ({p0.gnt, p1.gnt, mem_we} !== 3'b100) begin
            fails++;
            $display("FAIL rd_cycle got=%b want=100", {p0.gnt, p1.gnt, mem_we});
        end
        exp0.push_back('{16'hBEEF, 32'(cyc + RD_LAT)});
        tick();
        idle();
        for (int k = 0; k < 8 && got0.size() < exp0.size(); k++) tick();
        repeat (2) tick();
        tests++;
        if (got0.size() != exp0.size() || got1.size() != 0) begin
            fails++;
            $display("FAIL wr_rd_count got0=%0d want=%0d got1=%0d want=0",
                got0.size(), exp0.size(), got1.size());
        end
        while (exp0.size() > 0 && got0.size() > 0) begin
            e = exp0.pop_front();
            g = got0.pop_front();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL wr_rd_data got=%h@%0d want=%h@%0d", g.d, g.cyc, e.d, e.cyc);
            end
        end
        exp0.delete(); got0.delete(); got1.delete();
    endtask

    task automatic test_flush();
        apply_reset();
        p0.req = 1; p0.we = 0; p0.addr = 16'h0010;
        #1;
        tests++;
        if (p0.gnt !== 1'b1) begin
            fails++;
            $display("FAIL flush_issue got=%b want=1", p0.gnt);
        end
        tick();
        Resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if ({p0.gnt, p1.gnt, mem_we, p0.rvalid, busy} !== 5'b0) begin
                fails++;
                $display("FAIL flush_rst cyc%0d got=%b want=00000", i,
                    {p0.gnt, p1.gnt, mem_we, p0.rvalid, busy});
            end
            tick();
        end
        Resetn = 1'b1;
        idle();
        repeat (3) tick();
        tests++;
        if (got0.size() != 0) begin
            fails++;
            $display("FAIL flush_rvalid got=%0d want=0", got0.size());
        end
        got0.delete();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        p0.req = 1; p0.we = 1; p0.addr = 16'h0070; p0.wdata = 16'h7070;
        p1.req = 1; p1.we = 1; p1.addr = 16'h0071; p1.wdata = 16'h7171;
        repeat (10) tick();
        idle();
        #1;
        tests++;
        if ({stat_conflict, stat_gnt0, stat_gnt1} !== {16'd10, 16'd5, 16'd5}) begin
            fails++;
            $display("FAIL stats got=%0d/%0d/%0d want=10/5/5",
                stat_conflict, stat_gnt0, stat_gnt1);
        end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Resetn = 1'b0;
        idle();
        tick();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_burst_lock();
        test_write_read();
        test_flush();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        repeat (2) tick();
        tests++;
        if (exp0.size() + exp1.size() + got0.size() + got1.size() != 0) begin
            fails++;
            $display("FAIL stray_rvalid got=%0d want=0",
                exp0.size() + exp1.size() + got0.size() + got1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit RAM between the processor memory interface (port 0) and a DMA/loader engine (port 1).
- Grants one requester per cycle using round-robin with optional burst lock and a starvation cap.
- Tracks outstanding reads through the fixed RAM read latency and returns data to the correct owner.
- Sits between enhanced_proc/loader and RAM_1_PORT; the processor stalls (holds Run low) while its request is not granted.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles (1..4).
- MAX_BURST, 8, max consecutive locked grants to one port while the other port waits (2..255).

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Resetn  input  1  synchronous, active-low reset.
- req0  input  1  port 0 (CPU) access request.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- lock0  input  1  port 0 requests to keep the grant next cycle.
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- gnt0  output  1  port 0 access issued this cycle.
- rvalid0  output  1  port 0 read data valid.
- rdata0  output  DW  port 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (DMA).
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_rdata  input  DW  RAM read data, valid RD_LAT cycles after the address.
- busy  output  1  read pipeline non-empty or a grant is issued this cycle.

Behaviour:
- Reset (Resetn = 0 at a clock edge): clears last_owner (to 1, so port 0 wins the first tie), burst_cnt, and the read pipeline. While Resetn = 0, gnt0, gnt1, mem_we, rvalid0, rvalid1 and busy are forced 0. rdata0 and rdata1 are 0 when their rvalid is low.
- Grant is combinational from req and registered state. The access is issued in the same cycle it is granted. gnt0 and gnt1 are never both 1.
- Only one port requesting: grant that port.
- Both ports requesting:
  - Grant last_owner if its lock was high on its previous grant and burst_cnt < MAX_BURST.
  - Otherwise grant the port that is not last_owner (round-robin).
- No request: no grant; mem_we = 0; mem_addr and mem_wdata driven from port 0.
- State update on each grant:
  - last_owner is set to the granted port.
  - burst_cnt resets to 1 when the owner changes or the other port is not requesting. Otherwise it increments, saturating at MAX_BURST.
  - A cycle with no grant leaves last_owner unchanged and clears burst_cnt.
- Mux rules: mem_addr and mem_wdata come from the granted port. mem_we = the granted port's we.
- Reads: a granted read enters an RD_LAT-deep shift pipeline tagged with its owner. After exactly RD_LAT cycles the owner's rvalid pulses for 1 cycle with rdata = mem_rdata.
- Writes: produce no rvalid.
- Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- A request is held by the requester until granted. Inputs of a non-granted port are ignored.
- Reset mid-operation flushes the read pipeline: no rvalid is produced for reads issued before reset.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0 [15:0], stat_gnt1 [15:0] and stat_conflict [15:0], each cleared by reset.
  - stat_gnt0 and stat_gnt1 increment on each grant to their port.
  - stat_conflict increments each cycle both req are high.
  - All three counters saturate at 16'hFFFF.
- Not defined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0 = 1, we0 = 0, addr0 = 16'h0010, RAM[0x10] = 16'h1234 -> gnt0 = 1 the same cycle, mem_addr = 16'h0010; rvalid0 = 1 with rdata0 = 16'h1234 exactly 1 cycle later; gnt1 stays 0.
- req0 and req1 both held high, no lock, 6 cycles -> grants alternate 0,1,0,1,0,1 starting with port 0; no cycle has both gnts.
- req1 with lock1 = 1 and req0 held high, MAX_BURST = 4 -> gnt1 for 4 consecutive cycles, then gnt0 in cycle 5.
- Port 1 writes 16'hBEEF to 16'h0020 while port 0 waits, then port 0 reads 16'h0020 -> mem_we = 1 only in the write cycle; rvalid0 returns 16'hBEEF; no rvalid1 is produced.
- Port 0 issues a read; Resetn is driven low on the next edge before the data returns -> rvalid0 never asserts; all gnts and mem_we are 0 during reset.
- With ARB_STATS_EN: 10 cycles of both ports requesting -> stat_conflict = 10, stat_gnt0 = 5, stat_gnt1 = 5.
